// File: rtl/asm_irq_ctrl.sv
// Interrupt sequencer for the accelerator-domain PicoRV32: latches source edges,
// dispatches one IRQ at a time, tracks the EOI handshake and recovers from stuck handlers.
module asm_irq_ctrl #(
  parameter int unsigned NUM_IRQ       = 8,
  parameter int unsigned IRQ_BASE      = 3,
  parameter int unsigned REG_ADDR_SIZE = 32,
  parameter int unsigned REG_DATA_SIZE = 64,
  parameter int unsigned REG_BSEL_SIZE = 8,
  parameter logic [15:0] TIMEOUT_RST   = 16'd1024
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     config_en_i,
  input  logic [REG_BSEL_SIZE-1:0] config_wben_i,
  input  logic [REG_ADDR_SIZE-1:0] config_addr_i,
  input  logic [REG_DATA_SIZE-1:0] config_wdata_i,
  output logic [REG_DATA_SIZE-1:0] config_rdata_o,
  input  logic                     asm_en_i,
  input  logic [NUM_IRQ-1:0]       irq_src_i,
  output logic [31:0]              pico_irq_o,
  input  logic [31:0]              pico_eoi_i
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ASSERT,
    ST_SERVICE
  } state_t;

  localparam logic [REG_ADDR_SIZE-1:0] ADDR_MASK    = REG_ADDR_SIZE'(32'h00);
  localparam logic [REG_ADDR_SIZE-1:0] ADDR_PENDING = REG_ADDR_SIZE'(32'h08);
  localparam logic [REG_ADDR_SIZE-1:0] ADDR_ACTIVE  = REG_ADDR_SIZE'(32'h10);
  localparam logic [REG_ADDR_SIZE-1:0] ADDR_STATUS  = REG_ADDR_SIZE'(32'h18);
  localparam logic [REG_ADDR_SIZE-1:0] ADDR_TIMEOUT = REG_ADDR_SIZE'(32'h20);

  // State registers and their next-state values
  state_t                   state_q, state_d;
  logic [NUM_IRQ-1:0]       src_q;
  logic [NUM_IRQ-1:0]       pending_q, pending_d;
  logic [NUM_IRQ-1:0]       mask_q, mask_d;
  logic [NUM_IRQ-1:0]       act_q, act_d;
  logic [4:0]               id_q, id_d;
  logic                     irq_on_q, irq_on_d;
  logic [15:0]              timer_q, timer_d;
  logic [15:0]              timeout_q, timeout_d;
  logic                     err_q, err_d;
  logic [15:0]              tocnt_q, tocnt_d;
  logic [REG_DATA_SIZE-1:0] rdata_q, rdata_d;

  // Register-interface decode
  logic        wr_en, rd_en;
  logic        we_mask, we_pending, we_status, we_timeout;
  logic [31:0] wr_bmask;
  logic [31:0] wr_data;
  logic [31:0] rd_val;

  // Dispatch datapath
  logic [NUM_IRQ-1:0] src_edge;
  logic [NUM_IRQ-1:0] req;
  logic [NUM_IRQ-1:0] sel_oh;
  logic [4:0]         sel_id;
  logic [NUM_IRQ-1:0] disp_clr;
  logic [NUM_IRQ-1:0] repend;
  logic [NUM_IRQ-1:0] pend_clr;
  logic               eoi_hit;
  logic               tick;
  logic               timeout_hit;
  logic               sts_clr;
  logic               unused_ok;

  assign wr_en      = config_en_i && (config_wben_i != '0);
  assign rd_en      = config_en_i && (config_wben_i == '0);
  assign we_mask    = wr_en && (config_addr_i == ADDR_MASK);
  assign we_pending = wr_en && (config_addr_i == ADDR_PENDING);
  assign we_status  = wr_en && (config_addr_i == ADDR_STATUS);
  assign we_timeout = wr_en && (config_addr_i == ADDR_TIMEOUT);
  assign wr_data    = config_wdata_i[31:0];
  assign sts_clr    = we_status && config_wben_i[0];

  // NOTE: every signal driven from always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    wr_bmask = '0;
    for (int b = 0; b < 4; b++) begin
      wr_bmask[8*b +: 8] = {8{config_wben_i[b]}};
    end
  end

  assign pend_clr = we_pending ? (wr_data[NUM_IRQ-1:0] & wr_bmask[NUM_IRQ-1:0]) : '0;

  assign src_edge = irq_src_i & ~src_q;
  assign req      = pending_q & mask_q;
  // Two's-complement trick isolates the lowest requesting source.
  assign sel_oh   = req & (~req + NUM_IRQ'(1));
  assign eoi_hit  = |(pico_eoi_i[IRQ_BASE +: NUM_IRQ] & act_q);

  always_comb begin
    sel_id = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (req[i]) sel_id = 5'(i);
    end
  end

  // Dispatch FSM: next state, in-flight bookkeeping and watchdog timer
  always_comb begin
    state_d     = state_q;
    act_d       = act_q;
    id_d        = id_q;
    irq_on_d    = irq_on_q;
    timer_d     = timer_q;
    disp_clr    = '0;
    repend      = '0;
    timeout_hit = 1'b0;
    tick        = (timeout_q != 16'd0) && (timer_q != 16'd0);

    unique case (state_q)
      ST_IDLE: begin
        if (asm_en_i && (req != '0)) begin
          state_d  = ST_ASSERT;
          act_d    = sel_oh;
          id_d     = sel_id;
          irq_on_d = 1'b1;
          timer_d  = timeout_q;
          disp_clr = sel_oh;
        end
      end
      ST_ASSERT: begin
        if (!asm_en_i) begin
          // The core never saw this IRQ, so it goes back into PENDING.
          state_d  = ST_IDLE;
          irq_on_d = 1'b0;
          repend   = act_q;
        end else if (eoi_hit) begin
          state_d  = ST_SERVICE;
          irq_on_d = 1'b0;
          timer_d  = timeout_q;
        end else if (tick) begin
          timer_d = timer_q - 16'd1;
          if (timer_q == 16'd1) begin
            state_d     = ST_IDLE;
            irq_on_d    = 1'b0;
            timeout_hit = 1'b1;
          end
        end
      end
      ST_SERVICE: begin
        if (!asm_en_i || !eoi_hit) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          timer_d = timer_q - 16'd1;
          if (timer_q == 16'd1) begin
            state_d     = ST_IDLE;
            timeout_hit = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Register next-state: a source edge wins over both the dispatch clear and a W1C.
  always_comb begin
    pending_d = (pending_q & ~pend_clr & ~disp_clr) | repend | src_edge;

    mask_d = mask_q;
    if (we_mask) begin
      mask_d = (mask_q & ~wr_bmask[NUM_IRQ-1:0]) | (wr_data[NUM_IRQ-1:0] & wr_bmask[NUM_IRQ-1:0]);
    end

    timeout_d = timeout_q;
    if (we_timeout) begin
      timeout_d = (timeout_q & ~wr_bmask[15:0]) | (wr_data[15:0] & wr_bmask[15:0]);
    end

    err_d   = sts_clr ? 1'b0 : err_q;
    tocnt_d = sts_clr ? 16'd0 : tocnt_q;
    if (timeout_hit) begin
      err_d = 1'b1;
      if (tocnt_d != 16'hFFFF) tocnt_d = tocnt_d + 16'd1;
    end
  end

  always_comb begin
    rd_val = '0;
    case (config_addr_i)
      ADDR_MASK:    rd_val = 32'(mask_q);
      ADDR_PENDING: rd_val = 32'(pending_q);
      ADDR_ACTIVE:  rd_val = (state_q != ST_IDLE) ? {23'd0, 1'b1, 3'd0, id_q} : 32'd0;
      ADDR_STATUS:  rd_val = {8'd0, tocnt_q, 7'd0, err_q};
      ADDR_TIMEOUT: rd_val = {16'd0, timeout_q};
      default:      rd_val = '0;
    endcase
    rdata_d = rd_en ? REG_DATA_SIZE'(rd_val) : rdata_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= ST_IDLE;
      src_q     <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      act_q     <= '0;
      id_q      <= '0;
      irq_on_q  <= 1'b0;
      timer_q   <= '0;
      timeout_q <= TIMEOUT_RST;
      err_q     <= 1'b0;
      tocnt_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= irq_src_i;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      act_q     <= act_d;
      id_q      <= id_d;
      irq_on_q  <= irq_on_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
      tocnt_q   <= tocnt_d;
      rdata_q   <= rdata_d;
    end
  end

  assign pico_irq_o     = 32'(act_q & {NUM_IRQ{irq_on_q}}) << IRQ_BASE;
  assign config_rdata_o = rdata_q;

  // Upper data bytes, upper byte enables and EOI bits outside the source window are ignored.
  assign unused_ok = ^{config_wdata_i, config_wben_i, pico_eoi_i, wr_bmask, wr_data};

endmodule

// File: doc/asm_irq_ctrl.md
Name: asm_irq_ctrl

Overview:
Interrupt sequencer for the accelerator-domain PicoRV32 core. It collects up to NUM_IRQ synchronous interrupt sources into a pending register and dispatches them one at a time on pico_irq_o. It tracks each dispatch through the core's EOI handshake and recovers from stuck handlers with a timeout. Its configuration and status registers sit on the domain's TCU register interface, and its read data is registered.

Parameters:
NUM_IRQ, 8, number of external sources; legal range 1..(32-IRQ_BASE).
IRQ_BASE, 3, first pico_irq bit used. Bits 0..2 are reserved for the core's internal IRQs and are never driven.
REG_ADDR_SIZE, 32, config address width.
REG_DATA_SIZE, 64, config data width.
REG_BSEL_SIZE, 8, config byte-enable width.
TIMEOUT_RST, 16'd1024, reset value of the TIMEOUT register.

Ports:
clk_i  in  1  clock.
reset_n_i  in  1  asynchronous active-low reset.
config_en_i  in  1  register access strobe.
config_wben_i  in  REG_BSEL_SIZE  byte enables; nonzero means write, zero means read.
config_addr_i  in  REG_ADDR_SIZE  register address.
config_wdata_i  in  REG_DATA_SIZE  write data.
config_rdata_o  out  REG_DATA_SIZE  read data, valid 1 cycle after the read strobe.
asm_en_i  in  1  core enable; dispatch is allowed only when high.
irq_src_i  in  NUM_IRQ  interrupt sources, clk_i-synchronous; rising edge triggers.
pico_irq_o  out  32  one-hot IRQ to the core; bit IRQ_BASE+id.
pico_eoi_i  in  32  EOI vector from the core.

Behaviour:
- Reset: pico_irq_o=0, config_rdata_o=0, PENDING=0, MASK=0, ERR=0, TOCNT=0, TIMEOUT=TIMEOUT_RST, FSM=IDLE. A prior src sample of 0 is assumed, so a source already high at reset exit counts as an edge.
- Edge detect: PENDING[n] is set when irq_src_i[n]=1 and the previous sample was 0.
- Registers. Writes honour byte enables on bytes 0..3; bits above 31 are ignored; undefined addresses are write-ignored and read 0.
  - 0x00 MASK, RW. Bit n=1 enables source n.
  - 0x08 PENDING, R/W1C.
  - 0x10 ACTIVE, R. bit 8=valid, [4:0]=active id.
  - 0x18 STATUS, R/W1C. bit0 ERR, sticky timeout flag; [23:8]=TOCNT, saturating count of timeouts. Any write with byte 0 enabled clears both.
  - 0x20 TIMEOUT, RW, 16 bit. 0 disables the timeout.
- FSM states:
  - IDLE: if asm_en_i=1 and (PENDING & MASK)!=0, select the lowest set index id, clear PENDING[id], drive pico_irq_o bit IRQ_BASE+id next cycle, go to ASSERT, load the timer.
  - ASSERT: hold the IRQ bit until pico_eoi_i[IRQ_BASE+id]=1. Then deassert the IRQ next cycle, go to SERVICE, reload the timer.
  - SERVICE: wait for pico_eoi_i[IRQ_BASE+id]=0, then go to IDLE. The minimum gap between dispatches is one IDLE cycle.
- Timer: 16-bit down-counter in ASSERT and SERVICE when TIMEOUT!=0. On reaching 0: drop the IRQ, set ERR, increment TOCNT (saturate at 0xFFFF), go to IDLE. The id is not re-pended.
- asm_en_i falling: IRQ is deasserted next cycle and the FSM goes to IDLE.
  - From ASSERT, PENDING[id] is re-set, because the IRQ was not delivered.
  - From SERVICE, the IRQ is dropped silently.
- Simultaneous events:
  - An edge on a bit plus a W1C of the same bit in one cycle: set wins.
  - An edge on the bit being dispatched in the same cycle: it stays pending.
  - An edge on the active id during ASSERT or SERVICE sets PENDING normally.
- MASK changes do not affect an in-flight dispatch. A masked bit still latches pending.
- Reads return ACTIVE/PENDING values as of the read-strobe cycle. Reads and writes are never simultaneous; wben decides which.
- At most one pico_irq_o bit is high at any time, and never a bit outside [IRQ_BASE, IRQ_BASE+NUM_IRQ-1].

Test Plan:
- Reset, MASK=0xFF, asm_en=1, pulse src[2] -> PENDING bit2 set, then cleared. pico_irq_o=0x20 two cycles after the edge. eoi[5]=1 -> irq=0 next cycle; eoi[5]=0 -> FSM back to IDLE.
- Edges on src[1] and src[4] in the same cycle -> id1 is dispatched first (irq=0x10). id4 is dispatched (irq=0x80) only after eoi[4] falls.
- TIMEOUT=8, dispatch id0 with no EOI -> irq bit3 drops 8 cycles after ASSERT. STATUS reads 0x101. Writing STATUS=1 -> reads 0.
- MASK=0x00, pulse src[3] -> no IRQ, PENDING=0x08. Setting MASK=0x08 -> dispatch. Alternatively, W1C 0x08 before setting MASK -> no dispatch.
- asm_en=0 during ASSERT of id6 -> irq=0 next cycle and PENDING bit6 set again. asm_en=1 -> id6 is redispatched.
- Assert reset_n_i low during SERVICE -> immediate pico_irq_o=0 and all registers back to reset values. TIMEOUT reads 1024 (0x400).
